alu_1_sweep: RTL and testbench
==============================

ALU_1_SWEEP -- requirements
Module: alu_1_sweep

Interface
REQ-001 Parameter LAST_OP, default 10, meaning: highest CTRL code swept (legal 0..15).
REQ-002 Parameter SETTLE_CYCLES, default 2, meaning: wait cycles after each CTRL change before capture (legal >=1).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  sweep request, sampled when busy=0.
REQ-006 a_in, b_in  input  1 each  operand values latched at start.
REQ-007 alu_a, alu_b  output  1 each  operands driven to the 1-bit ALU slice.
REQ-008 alu_ctrl  output  4  opcode driven to the ALU slice.
REQ-009 alu_out  input  2  ALU slice result, captured by this block.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  single-cycle pulse at sweep completion.
REQ-012 rd_addr  input  4  result buffer read index.
REQ-013 rd_data  output  2  registered result buffer read data.

Function
REQ-014 FSM states IDLE, SETTLE, CAPTURE, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> latch a_in/b_in into alu_a/alu_b, op counter=0, alu_ctrl=0, settle counter loaded, go SETTLE; busy=1 from next cycle.
REQ-016 SETTLE: hold alu_a/alu_b/alu_ctrl stable for exactly SETTLE_CYCLES cycles, then go CAPTURE.
REQ-017 CAPTURE (one cycle): write alu_out into buffer[op]; if op==LAST_OP go DONE, else op+1, alu_ctrl+1, reload settle counter, go SETTLE.
REQ-018 DONE (one cycle): done=1, busy=1; next state IDLE, busy=0, alu_ctrl=0; alu_a/alu_b keep last latched values.
REQ-019 Latency: done high in cycle (LAST_OP+1)*(SETTLE_CYCLES+1)+1 after the cycle start was sampled (34 with defaults).
REQ-020 start while busy=1 (incl. DONE cycle) ignored, no queuing; a_in/b_in changes mid-sweep have no effect.
REQ-021 Buffer: 16 x 2 bits; a sweep writes only entries 0..LAST_OP; entries above LAST_OP keep prior contents.
REQ-022 rd_data = buffer[rd_addr] one cycle after rd_addr sampled; reads allowed any time, incl. during a sweep.
REQ-023 Read and capture of same index in same cycle: rd_data returns old value; new value visible from next read.
REQ-024 LAST_OP=15: op counter terminates at 15, no wrap to 0; alu_ctrl never exceeds LAST_OP.

Reset
REQ-025 rst_n low asynchronously forces IDLE, busy=0, done=0, alu_a=0, alu_b=0, alu_ctrl=0, rd_data=0, all buffer entries 0, counters 0.
REQ-026 Reset mid-sweep aborts it; no done pulse; release resumes in IDLE needing a new start.

Configuration
REQ-027 Macro ALU_1_SWEEP_SIG_EN defined: extra output sig (8 bits); cleared to 0 on accepted start and by reset; each CAPTURE sets sig = (sig rotated left by 1) XOR {6'b0, alu_out}; stable from DONE until next start.
REQ-028 ALU_1_SWEEP_SIG_EN undefined: no sig port and no signature logic; all other behaviour identical.

Verification
(Bench drives alu_out from a stub: alu_out = alu_ctrl[1:0] XOR {alu_a, alu_b}.)
REQ-029 Reset, start pulse with a_in=1, b_in=0, defaults -> done once in cycle 34; busy high cycles 1..34; buffer[k] = k[1:0] XOR 2'b10 for k=0..10 (buffer[0]=2, buffer[3]=1, buffer[10]=0).
REQ-030 After REQ-029, read rd_addr=11..15 -> rd_data=0; rd_addr=5 -> rd_data=3 one cycle later.
REQ-031 start re-pulsed at cycles 5 and 34 of a sweep -> ignored, exactly one done; busy low cycle 35.
REQ-032 rst_n low at cycle 12 of a sweep -> busy=0, alu_ctrl=0, all rd_data reads 0, no done; new start with a_in=0,b_in=1 -> buffer[2]=3, done in 34.
REQ-033 LAST_OP=15, SETTLE_CYCLES=1 -> done in cycle 33, buffer[15]=1, alu_ctrl sequence 0..15 then 0.
REQ-034 ALU_1_SWEEP_SIG_EN defined, stimulus of REQ-029 -> sig equals the bench's rotate-XOR model over captures 0..10; reset -> sig=0.

Source files
------------

// File: rtl/alu_1_sweep.sv
// alu_1_sweep: steps a 1-bit ALU slice through opcodes 0..LAST_OP with fixed
// operands, waits SETTLE_CYCLES after each opcode change, and stores each
// 2-bit result in a 16-entry buffer readable at any time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               sweep request (ignored while busy)
//   a_in, b_in          operands latched on an accepted start
//   alu_a, alu_b        operands driven to the ALU slice
//   alu_ctrl[3:0]       opcode driven to the ALU slice
//   alu_out[1:0]        ALU slice result
//   busy, done          sweep in progress / one-cycle completion pulse
//   rd_addr[3:0]        result buffer read index
//   rd_data[1:0]        registered buffer read data
//   sig[7:0]            rotate-XOR signature of the captures
//                       (present only when ALU_1_SWEEP_SIG_EN is defined)
module alu_1_sweep #(
    parameter int unsigned LAST_OP       = 10,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       a_in,
    input  logic       b_in,
    output logic       alu_a,
    output logic       alu_b,
    output logic [3:0] alu_ctrl,
    input  logic [1:0] alu_out,
    output logic       busy,
    output logic       done,
    input  logic [3:0] rd_addr,
    output logic [1:0] rd_data
`ifdef ALU_1_SWEEP_SIG_EN
    ,
    output logic [7:0] sig
`endif
);

    localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DEPTH   = 16;
    localparam logic [3:0]  OP_LAST = 4'(LAST_OP);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic [1:0]        res_q [DEPTH];
    logic [1:0]        rd_data_q;
`ifdef ALU_1_SWEEP_SIG_EN
    logic [7:0]        sig_q, sig_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
`ifdef ALU_1_SWEEP_SIG_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = 4'd0;
                    ctrl_d  = 4'd0;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    busy_d  = 1'b1;
                    state_d = SETTLE;
`ifdef ALU_1_SWEEP_SIG_EN
                    sig_d   = 8'd0;
`endif
                end
            end
            SETTLE: begin
                // Counter is loaded with SETTLE_CYCLES, so leaving at 1 gives
                // exactly SETTLE_CYCLES cycles in this state.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                wr_en = 1'b1;
`ifdef ALU_1_SWEEP_SIG_EN
                sig_d = {sig_q[6:0], sig_q[7]} ^ {6'b0, alu_out};
`endif
                if (op_q == OP_LAST) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    op_d    = op_q + 4'd1;
                    ctrl_d  = ctrl_q + 4'd1;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    state_d = SETTLE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                ctrl_d  = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, control and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            ctrl_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) res_q[i] <= '0;
`ifdef ALU_1_SWEEP_SIG_EN
            sig_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            // Read sees the pre-write contents when indices collide.
            rd_data_q <= res_q[rd_addr];
            if (wr_en) res_q[op_q] <= alu_out;
`ifdef ALU_1_SWEEP_SIG_EN
            sig_q     <= sig_d;
`endif
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = ctrl_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
`ifdef ALU_1_SWEEP_SIG_EN
    assign sig      = sig_q;
`endif

endmodule

// File: tb/tb_alu_1_sweep.sv
// Self-checking bench for alu_1_sweep: one instance with default parameters
// and one with LAST_OP=15, SETTLE_CYCLES=1, each driven by a stub ALU slice.
module tb_alu_1_sweep;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a_in;
    logic       b_in;
    logic [3:0] rd_addr;
    logic       sel;

    logic       start0, start1;
    logic       alu_a0, alu_b0, alu_a1, alu_b1;
    logic [3:0] ctrl0, ctrl1;
    logic [1:0] out0, out1;
    logic       busy0, busy1, done0, done1;
    logic [1:0] rd0, rd1;
`ifdef ALU_1_SWEEP_SIG_EN
    logic [7:0] sig0, sig1;
    logic [7:0] exp_sig [2];
`endif

    int         n_checks;
    int         n_errors;
    logic [1:0] exp_buf [2][16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign out0   = ctrl0[1:0] ^ {alu_a0, alu_b0};
    assign out1   = ctrl1[1:0] ^ {alu_a1, alu_b1};

    wire       busy_m = sel ? busy1 : busy0;
    wire       done_m = sel ? done1 : done0;
    wire [3:0] ctrl_m = sel ? ctrl1 : ctrl0;
    wire       a_m    = sel ? alu_a1 : alu_a0;
    wire       b_m    = sel ? alu_b1 : alu_b0;
    wire [1:0] rd_m   = sel ? rd1 : rd0;
`ifdef ALU_1_SWEEP_SIG_EN
    wire [7:0] sig_m  = sel ? sig1 : sig0;
`endif

    alu_1_sweep dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start0),
        .a_in    (a_in),
        .b_in    (b_in),
        .alu_a   (alu_a0),
        .alu_b   (alu_b0),
        .alu_ctrl(ctrl0),
        .alu_out (out0),
        .busy    (busy0),
        .done    (done0),
        .rd_addr (rd_addr),
        .rd_data (rd0)
`ifdef ALU_1_SWEEP_SIG_EN
        ,
        .sig     (sig0)
`endif
    );

    alu_1_sweep #(.LAST_OP(15), .SETTLE_CYCLES(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .a_in    (a_in),
        .b_in    (b_in),
        .alu_a   (alu_a1),
        .alu_b   (alu_b1),
        .alu_ctrl(ctrl1),
        .alu_out (out1),
        .busy    (busy1),
        .done    (done1),
        .rd_addr (rd_addr),
        .rd_data (rd1)
`ifdef ALU_1_SWEEP_SIG_EN
        ,
        .sig     (sig1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) exp_buf[s][i] = 2'd0;
`ifdef ALU_1_SWEEP_SIG_EN
            exp_sig[s] = 8'd0;
`endif
        end
    endtask

    task automatic read_check(input int idx);
        rd_addr = 4'(idx);
        @(posedge clk);
        #1;
        check("rd_data", 32'(rd_m), 32'(exp_buf[sel][idx]));
    endtask

    task automatic read_all(input bit s);
        sel = s;
        for (int i = 0; i < 16; i++) read_check(i);
    endtask

    // One full sweep on instance s; optional start re-pulses at cycles 5 and D.
    task automatic run_sweep(input bit s, input logic a, input logic b, input bit repulse);
        int         last, settle, dcyc_exp, ndone, dcyc, ridx;
        logic [1:0] old_val, new_val, exp_rd;
        logic [3:0] ectrl;
        last     = s ? 15 : 10;
        settle   = s ? 1 : 2;
        dcyc_exp = (last + 1) * (settle + 1) + 1;
        ridx     = int'($urandom_range(0, 15));
        sel      = s;
        @(posedge clk);
        #1;
        a_in    = a;
        b_in    = b;
        start   = 1'b1;
        rd_addr = 4'(ridx);
        @(posedge clk);
        #1;
        start   = 1'b0;
        a_in    = ~a;
        b_in    = ~b;
        old_val = exp_buf[s][ridx];
        new_val = 2'(ridx) ^ {a, b};
        ndone   = 0;
        dcyc    = 0;
        for (int c = 1; c <= dcyc_exp + 1; c++) begin
            check("busy", 32'(busy_m), 32'(c <= dcyc_exp));
            if (c < dcyc_exp)       ectrl = 4'((c - 1) / (settle + 1));
            else if (c == dcyc_exp) ectrl = 4'(last);
            else                    ectrl = 4'd0;
            check("alu_ctrl", 32'(ctrl_m), 32'(ectrl));
            // Entry ridx is captured in cycle (ridx+1)*(settle+1) and becomes
            // readable through rd_data two cycles later.
            if (ridx <= last && (ridx + 1) * (settle + 1) <= c - 2) exp_rd = new_val;
            else                                                   exp_rd = old_val;
            check("rd_during_sweep", 32'(rd_m), 32'(exp_rd));
            if (done_m) begin
                ndone++;
                dcyc = c;
            end
            start = repulse && (c == 5 || c == dcyc_exp);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("done_count", 32'(ndone), 32'd1);
        check("done_cycle", 32'(dcyc), 32'(dcyc_exp));
        check("alu_a_kept", 32'(a_m), 32'(a));
        check("alu_b_kept", 32'(b_m), 32'(b));
        for (int k = 0; k <= last; k++) exp_buf[s][k] = 2'(k) ^ {a, b};
`ifdef ALU_1_SWEEP_SIG_EN
        exp_sig[s] = 8'd0;
        for (int k = 0; k <= last; k++)
            exp_sig[s] = {exp_sig[s][6:0], exp_sig[s][7]} ^ {6'b0, 2'(k) ^ {a, b}};
        check("sig", 32'(sig_m), 32'(exp_sig[s]));
`endif
    endtask

    // Start a sweep on the default instance and reset it in cycle 12.
    task automatic reset_mid();
        int ndone;
        sel = 1'b0;
        @(posedge clk);
        #1;
        a_in  = 1'($urandom_range(0, 1));
        b_in  = 1'($urandom_range(0, 1));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c < 12; c++) begin
            if (done0) ndone++;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        clear_model();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_ctrl", 32'(ctrl0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_alu_a", 32'(alu_a0), 32'd0);
`ifdef ALU_1_SWEEP_SIG_EN
        check("rst_sig", 32'(sig0), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (done0) ndone++;
            check("idle_after_rst", 32'(busy0), 32'd0);
            @(posedge clk);
            #1;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a_in     = 1'b0;
        b_in     = 1'b0;
        rd_addr  = 4'd0;
        sel      = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_done0", 32'(done0), 32'd0);
        check("reset_ctrl0", 32'(ctrl0), 32'd0);
        check("reset_ab0", 32'({alu_a0, alu_b0}), 32'd0);
        check("reset_rd0", 32'(rd0), 32'd0);
        check("reset_busy1", 32'(busy1), 32'd0);
        check("reset_ctrl1", 32'(ctrl1), 32'd0);
        rst_n = 1'b1;

        run_sweep(1'b0, 1'b1, 1'b0, 1'b0);
        read_all(1'b0);
        check("buf0_eq2", 32'(exp_buf[0][0]), 32'd2);
        sel = 1'b0;
        read_check(5);

        run_sweep(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        read_all(1'b0);

        reset_mid();
        read_all(1'b0);
        read_all(1'b1);
        run_sweep(1'b0, 1'b0, 1'b1, 1'b0);
        read_all(1'b0);

        run_sweep(1'b1, 1'b1, 1'b0, 1'b0);
        read_all(1'b1);

        for (int n = 0; n < 6; n++) begin
            run_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int r = 0; r < 6; r++) read_check(int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
